// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch constants, fetch-state encoding,
// and the IF/ID pipeline payload.
package cpu_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned PC_STEP     = 4;
  localparam int unsigned PERF_FETCH_W = 32;
  localparam int unsigned PERF_EVT_W   = 16;

  // Encoding of the NOP word placed in IF/ID on reset or flush.
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    HOLD     = 2'd2,
    REDIRECT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
    logic              valid;
  } if_id_t;

  // Clear the byte-offset bits so the PC always holds a word address.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & {{(WORD_W-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_pipeline_register.sv
// IF/ID pipeline register: holds the fetched word, its PC+step and a valid bit.
// Flush wins over load and inserts a bubble (NOP, pc4 cleared, valid low).
module if_id_pipeline_register
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // Register update: reset, then flush, then load; otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q.instr <= NOP_INSTR;
      q.pc4   <= '0;
      q.valid <= 1'b0;
    end else if (flush) begin
      q.instr <= NOP_INSTR;
      q.pc4   <= '0;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, fetch FSM and IF/ID register.
// Optional build macro IF_FETCH_PERF_EN adds saturating fetch/stall/flush
// performance counters as extra outputs.
module if_fetch_stage #(
  parameter logic [cpu_pkg::WORD_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned                PC_STEP   = cpu_pkg::PC_STEP,
  parameter logic [cpu_pkg::WORD_W-1:0] NOP_INSTR = cpu_pkg::NOP_WORD
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [cpu_pkg::WORD_W-1:0]    imem_addr,
  input  logic [cpu_pkg::WORD_W-1:0]    imem_data,
  input  logic                          pc_ld,
  input  logic                          if_id_ld,
  input  logic                          br_taken,
  input  logic [cpu_pkg::WORD_W-1:0]    br_target,
  output logic [cpu_pkg::WORD_W-1:0]    pc,
  output logic [cpu_pkg::WORD_W-1:0]    id_instr,
  output logic [cpu_pkg::WORD_W-1:0]    id_pc4,
  output logic                          id_valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [cpu_pkg::PERF_FETCH_W-1:0] perf_fetch,
  output logic [cpu_pkg::PERF_EVT_W-1:0]   perf_stall,
  output logic [cpu_pkg::PERF_EVT_W-1:0]   perf_flush
`endif
);
  import cpu_pkg::*;

  localparam logic [WORD_W-1:0] STEP = WORD_W'(PC_STEP);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [WORD_W-1:0] pc_next;
  logic [WORD_W-1:0] pc_plus;
  logic              ifid_load;
  logic              ifid_flush;
  if_id_t            ifid_d;
  if_id_t            ifid_q;

  // Sequential fetch address; wraps modulo 2^32 silently.
  assign pc_plus   = pc + STEP;
  assign imem_addr = pc;

  // Fetch-state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next state, next PC and IF/ID control; a redirect outranks both enables.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    case (state)
      BOOT: begin
        // ID still holds the reset bubble, so no branch can be pending.
        if (pc_ld) pc_next = pc_plus;
        ifid_load  = if_id_ld;
        state_next = RUN;
      end
      RUN, HOLD: begin
        if (br_taken) begin
          pc_next    = word_align(br_target);
          ifid_flush = 1'b1;
          state_next = REDIRECT;
        end else begin
          if (pc_ld) pc_next = pc_plus;
          ifid_load  = if_id_ld;
          state_next = (pc_ld && if_id_ld) ? RUN : HOLD;
        end
      end
      REDIRECT: begin
        // The bubble now in ID cannot raise a real branch; br_taken is ignored.
        if (pc_ld) pc_next = pc_plus;
        ifid_load  = if_id_ld;
        state_next = RUN;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  assign ifid_d = '{instr: imem_data, pc4: pc_plus, valid: 1'b1};

  if_id_pipeline_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign id_instr = ifid_q.instr;
  assign id_pc4   = ifid_q.pc4;
  assign id_valid = ifid_q.valid;

`ifdef IF_FETCH_PERF_EN
  logic stall_evt;

  // A stall cycle is any cycle with an enable low that is not itself a redirect.
  assign stall_evt = !ifid_flush && (!pc_ld || !if_id_ld);

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (ifid_load && (perf_fetch != '1)) perf_fetch <= perf_fetch + PERF_FETCH_W'(1);
      if (stall_evt && (perf_stall != '1)) perf_stall <= perf_stall + PERF_EVT_W'(1);
      if (ifid_flush && (perf_flush != '1)) perf_flush <= perf_flush + PERF_EVT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: vector table plus directed
// branch/stall sequences, expected values queued and compared after each edge.
module tb_if_fetch_stage;

  localparam logic [31:0] W   = 32'hE082_5005;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_ld;
  logic        if_id_ld;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [15:0] perf_stall;
  logic [15:0] perf_flush;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Behavioural instruction ROM: the low 16 bytes return one fixed word,
  // every other address returns a word tagged with its own address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a < 32'h10) return W;
    return {16'hE000, a[15:0]};
  endfunction

  assign imem_data = rom(imem_addr);

  if_fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .pc_ld     (pc_ld),
    .if_id_ld  (if_id_ld),
    .br_taken  (br_taken),
    .br_target (br_target),
    .pc        (pc),
    .id_instr  (id_instr),
    .id_pc4    (id_pc4),
    .id_valid  (id_valid)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
`endif
  );

  typedef struct {
    bit          rst;
    bit          pld;
    bit          ild;
    bit          brt;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    bit          e_valid;
    bit          chk_perf;
    logic [31:0] e_pf;
    logic [15:0] e_ps;
    logic [15:0] e_pfl;
  } vec_t;

  vec_t vecs[19];
  vec_t sb[$];

  function automatic vec_t mk(bit rst, bit pld, bit ild, bit brt, logic [31:0] tgt,
                              logic [31:0] e_pc, logic [31:0] e_instr,
                              logic [31:0] e_pc4, bit e_valid);
    vec_t v;
    v.rst = rst; v.pld = pld; v.ild = ild; v.brt = brt; v.tgt = tgt;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    v.chk_perf = 1'b0; v.e_pf = '0; v.e_ps = '0; v.e_pfl = '0;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    reset     = v.rst;
    pc_ld     = v.pld;
    if_id_ld  = v.ild;
    br_taken  = v.brt;
    br_target = v.tgt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s sb: got empty queue, expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check32({tag, " pc"},        pc,        e.e_pc);
      check32({tag, " imem_addr"}, imem_addr, e.e_pc);
      check32({tag, " id_instr"},  id_instr,  e.e_instr);
      check32({tag, " id_pc4"},    id_pc4,    e.e_pc4);
      check32({tag, " id_valid"},  32'(id_valid), 32'(e.e_valid));
`ifdef IF_FETCH_PERF_EN
      if (e.chk_perf) begin
        check32({tag, " perf_fetch"}, perf_fetch,      e.e_pf);
        check32({tag, " perf_stall"}, 32'(perf_stall), 32'(e.e_ps));
        check32({tag, " perf_flush"}, 32'(perf_flush), 32'(e.e_pfl));
      end
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] tgt;
    int          n;

    // rst pld ild brt tgt            -> pc           instr        pc4          valid
    vecs[0]  = mk(1, 1, 1, 0, 32'h0,        32'h0,        NOP,         32'h0,       0);
    vecs[1]  = mk(0, 1, 1, 0, 32'h0,        32'h4,        W,           32'h4,       1);
    vecs[2]  = mk(0, 1, 1, 0, 32'h0,        32'h8,        W,           32'h8,       1);
    vecs[3]  = mk(0, 0, 0, 0, 32'h0,        32'h8,        W,           32'h8,       1);
    vecs[4]  = mk(0, 0, 0, 0, 32'h0,        32'h8,        W,           32'h8,       1);
    vecs[5]  = mk(0, 1, 1, 0, 32'h0,        32'hC,        W,           32'hC,       1);
    vecs[6]  = mk(0, 1, 1, 1, 32'h40,       32'h40,       NOP,         32'h0,       0);
    vecs[7]  = mk(0, 1, 1, 1, 32'h100,      32'h44,       32'hE0000040, 32'h44,     1);
    vecs[8]  = mk(0, 1, 0, 0, 32'h0,        32'h48,       32'hE0000040, 32'h44,     1);
    vecs[9]  = mk(0, 0, 1, 0, 32'h0,        32'h48,       32'hE0000048, 32'h4C,     1);
    vecs[10] = mk(0, 0, 0, 1, 32'h83,       32'h80,       NOP,         32'h0,       0);
    vecs[11] = mk(1, 1, 1, 1, 32'h0,        32'h0,        NOP,         32'h0,       0);
    vecs[12] = mk(0, 1, 1, 0, 32'h0,        32'h4,        W,           32'h4,       1);
    vecs[13] = mk(0, 1, 1, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, NOP,         32'h0,       0);
    vecs[14] = mk(0, 1, 1, 0, 32'h0,        32'h0,        32'hE000FFFC, 32'h0,      1);
    vecs[15] = mk(0, 1, 1, 0, 32'h0,        32'h4,        W,           32'h4,       1);
    vecs[16] = mk(1, 1, 1, 0, 32'h0,        32'h0,        NOP,         32'h0,       0);
    vecs[17] = mk(0, 1, 0, 0, 32'h0,        32'h4,        NOP,         32'h0,       0);
    vecs[18] = mk(0, 1, 1, 0, 32'h0,        32'h8,        W,           32'h8,       1);
    vecs[10].chk_perf = 1'b1; vecs[10].e_pf = 32'd5; vecs[10].e_ps = 16'd4; vecs[10].e_pfl = 16'd2;
    vecs[11].chk_perf = 1'b1; vecs[11].e_pf = 32'd0; vecs[11].e_ps = 16'd0; vecs[11].e_pfl = 16'd0;
    vecs[17].chk_perf = 1'b1; vecs[17].e_pf = 32'd0; vecs[17].e_ps = 16'd1; vecs[17].e_pfl = 16'd0;

    for (int i = 0; i < 19; i++) begin
      step($sformatf("v%0d", i), vecs[i]);
    end

    // Random redirects (unaligned targets, random enables), ignored second
    // branch, then a stall of random length and its release.
    for (int k = 0; k < 6; k++) begin
      tgt = $urandom;
      a   = tgt & 32'hFFFF_FFFC;
      step($sformatf("br%0d", k),
           mk(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, tgt, a, NOP, 32'h0, 0));
      step($sformatf("rd%0d", k),
           mk(0, 1, 1, 1, $urandom, a + 32'd4, rom(a), a + 32'd4, 1));
      n = $urandom_range(2, 5);
      for (int s = 0; s < n; s++) begin
        step($sformatf("st%0d_%0d", k, s),
             mk(0, 0, 0, 0, 32'h0, a + 32'd4, rom(a), a + 32'd4, 1));
      end
      step($sformatf("rl%0d", k),
           mk(0, 1, 1, 0, 32'h0, a + 32'd8, rom(a + 32'd4), a + 32'd8, 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the pipelined ARM-subset CPU. It owns the PC register, drives the instruction RAM address, and forms the IF/ID pipeline register that feeds the control unit and ID-stage decode. It obeys the hazard unit's PC/IF_ID load enables and the ID-stage branch redirect (target address plus NOP select).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment per sequential fetch.
NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on flush or reset.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
imem_addr  out  32  byte address to instruction RAM (combinational read); equals pc.
imem_data  in  32  instruction word returned for imem_addr in the same cycle.
pc_ld  in  1  hazard unit PC load enable; 0 holds the PC.
if_id_ld  in  1  hazard unit IF/ID load enable; 0 holds the IF/ID register.
br_taken  in  1  ID-stage taken-branch select (TA vs PC+4, and NOP insert).
br_target  in  32  branch target address from the ID-stage target adder.
pc  out  32  current fetch PC.
id_instr  out  32  IF/ID instruction register.
id_pc4  out  32  IF/ID copy of fetch PC + PC_STEP.
id_valid  out  1  1 = id_instr is a real fetched instruction, 0 = bubble.

Behaviour:
- Reset (any cycle, including mid-stall or mid-redirect): pc=RESET_PC, id_instr=NOP_INSTR, id_pc4=0, id_valid=0, state=BOOT; all pending redirects are discarded.
- pc_plus = pc + PC_STEP, 32-bit modulo; 32'hFFFF_FFFC wraps to 0 with no flag.
- Latency: the word at pc appears on id_instr one cycle after pc is presented.
- FSM states: BOOT, RUN, HOLD, REDIRECT.
- BOOT: the first cycle after reset. Fetches RESET_PC and captures it into IF/ID only if if_id_ld=1. Goes to RUN.
- RUN:
  - If br_taken=1: pc<=br_target; IF/ID<=NOP_INSTR with id_valid=0; go to REDIRECT.
  - Else if pc_ld=0 or if_id_ld=0: go to HOLD.
  - Else: pc<=pc_plus; id_instr<=imem_data; id_pc4<=pc_plus; id_valid<=1.
- Enables are independent:
  - pc_ld=0 holds pc.
  - if_id_ld=0 holds id_instr, id_pc4 and id_valid.
  - pc_ld=1 with if_id_ld=0 is legal: pc advances and the IF/ID contents persist.
- HOLD: same update rules as RUN. Return to RUN on the first cycle where both enables are 1.
- REDIRECT: the fetch of br_target. br_taken is ignored for one cycle, because the bubble in ID cannot assert it. Then normal RUN update, and go to RUN.
- Priority: reset > br_taken > enables. A flush overrides if_id_ld=0, and a redirect loads pc even when pc_ld=0.
- br_target[1:0] != 0: the low two bits are forced to 0 when loaded into pc.
- The stage never reads imem_data in a cycle where IF/ID does not load.

Optional Feature:
Macro IF_FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch (32), perf_stall (16) and perf_flush (16). All are cleared on reset and saturate at all-ones.
  - perf_fetch counts cycles with id_valid loaded as 1.
  - perf_stall counts cycles with pc_ld=0 or if_id_ld=0 and no redirect.
  - perf_flush counts accepted br_taken.
- Undefined: the ports and counters are absent, and the core behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - WORD_W=32.
  - The NOP encoding constant.
  - The fetch-state enum (BOOT/RUN/HOLD/REDIRECT).
  - PC_STEP.
- One natural sub-module: if_id_pipeline_register. It holds id_instr/id_pc4/id_valid with load and flush inputs. The PC register and FSM stay in the top.

Test Plan:
- Reset then free-run for 4 cycles with imem returning 0xE0825005 at every address:
  - pc = 0, 4, 8, 12.
  - id_valid=0 in the cycle after reset, then 1.
  - id_pc4 = 4, 8, 12.
- Stall: pc_ld=0 and if_id_ld=0 for 2 cycles at pc=8 → pc stays 8, and id_instr/id_pc4 are held. Release → pc=12 next cycle.
- Taken branch: br_taken=1, br_target=0x40 at pc=12 → next cycle pc=0x40, id_instr=0, id_valid=0. br_taken=1 in the following cycle is ignored. Then pc=0x44.
- Flush during stall: br_taken=1 with if_id_ld=0 and pc_ld=0, br_target=0x80 → pc=0x80 and a bubble in ID.
- Reset asserted in the REDIRECT cycle → pc=RESET_PC, id_valid=0, state BOOT.
- Wrap: pc=0xFFFFFFFC, enables=1 → pc=0 and id_pc4=0. Under IF_FETCH_PERF_EN, the perf_fetch/stall/flush counts match the preceding scenarios.
